pcie_hcmd_slot_arb: RTL and testbench

PCIE_HCMD_SLOT_ARB -- requirements
Module: pcie_hcmd_slot_arb

---
 rtl/pcie_hcmd_slot_arb.sv | 198 +++++++++++++++++++
 tb/tb_pcie_hcmd_slot_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_hcmd_slot_arb.sv
`default_nettype none
// =============================================================================
// Module   : pcie_hcmd_slot_arb
// Brief    : Round-robin slot-tag allocator with merged completion/abort release.
// Revision : 1.0 - initial release
// =============================================================================
module pcie_hcmd_slot_arb #(
   parameter int P_REQ_NUM        = 4,
   parameter int P_SLOT_TAG_WIDTH = 10,
   parameter int P_ABT_FIFO_DEPTH = 4
) (
   input  logic                        pcie_user_clk,
   input  logic                        pcie_user_rst_n,
   input  logic [P_REQ_NUM-1:0]        req_slot_req,
   output logic [P_REQ_NUM-1:0]        req_slot_gnt,
   output logic [P_SLOT_TAG_WIDTH-1:0] req_slot_tag,
   input  logic                        hcmd_slot_rdy,
   input  logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_tag,
   output logic                        hcmd_slot_alloc_en,
   input  logic                        cpl_free_en,
   input  logic [P_SLOT_TAG_WIDTH-1:0] cpl_free_tag,
   input  logic                        abt_free_en,
   input  logic [P_SLOT_TAG_WIDTH-1:0] abt_free_tag,
   output logic                        hcmd_slot_free_en,
   output logic [P_SLOT_TAG_WIDTH-1:0] hcmd_slot_invalid_tag,
   output logic                        abt_free_full,
   output logic                        free_ovf_err,
   output logic [P_SLOT_TAG_WIDTH:0]   slot_used_cnt
);

   localparam int PTR_W   = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
   localparam int FIFO_AW = (P_ABT_FIFO_DEPTH > 1) ? $clog2(P_ABT_FIFO_DEPTH) : 1;
   localparam int FIFO_CW = $clog2(P_ABT_FIFO_DEPTH + 1);
   localparam logic [FIFO_CW-1:0]        FIFO_FULL_CNT = FIFO_CW'(P_ABT_FIFO_DEPTH);
   localparam logic [PTR_W-1:0]          RR_LAST       = PTR_W'(P_REQ_NUM - 1);
   localparam logic [FIFO_AW-1:0]        FIFO_LAST     = FIFO_AW'(P_ABT_FIFO_DEPTH - 1);
   localparam logic [P_SLOT_TAG_WIDTH:0] CNT_MAX       = {1'b1, {P_SLOT_TAG_WIDTH{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE = 3'b001,
      S_GNT  = 3'b010,
      S_WAIT = 3'b100
   } state_t;

   state_t                      state_q, state_d;
   logic [PTR_W-1:0]            rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]            winner_q, winner_d;
   logic [PTR_W-1:0]            rr_idx, rr_pick;
   logic                        rr_found;
   logic [P_REQ_NUM-1:0]        gnt_q, gnt_d;
   logic [P_SLOT_TAG_WIDTH-1:0] tag_q, tag_d;
   logic                        alloc_q, alloc_d;

   logic [P_SLOT_TAG_WIDTH-1:0] fifo_mem_q [P_ABT_FIFO_DEPTH];
   logic [FIFO_AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [FIFO_CW-1:0]          fifo_cnt_q, fifo_cnt_d;
   logic                        fifo_push, fifo_pop, fifo_drop;
   logic                        free_en_q, free_en_d;
   logic [P_SLOT_TAG_WIDTH-1:0] free_tag_q, free_tag_d;
   logic                        ovf_q, ovf_d;
   logic [P_SLOT_TAG_WIDTH:0]   used_cnt_q, used_cnt_d;

   // First requester at or after the pointer, wrapping modulo P_REQ_NUM.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = rr_ptr_q;
      rr_idx   = '0;
      for (int i = 0; i < P_REQ_NUM; i++) begin
         rr_idx = PTR_W'((int'(rr_ptr_q) + i) % P_REQ_NUM);
         if (!rr_found && req_slot_req[rr_idx]) begin
            rr_found = 1'b1;
            rr_pick  = rr_idx;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      winner_d = winner_q;
      gnt_d    = '0;
      tag_d    = '0;
      alloc_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hcmd_slot_rdy && rr_found) begin
               winner_d = rr_pick;
               state_d  = S_GNT;
            end
         end
         S_GNT: begin
            alloc_d         = 1'b1;
            gnt_d[winner_q] = 1'b1;
            tag_d           = hcmd_slot_tag;
            rr_ptr_d        = (winner_q == RR_LAST) ? '0 : winner_q + 1'b1;
            state_d         = S_WAIT;
         end
         S_WAIT: begin
            if (!hcmd_slot_rdy) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A full FIFO drops the push even if the head is popped in the same cycle.
   always_comb begin
      fifo_push  = abt_free_en && (fifo_cnt_q != FIFO_FULL_CNT);
      fifo_drop  = abt_free_en && (fifo_cnt_q == FIFO_FULL_CNT);
      fifo_pop   = !cpl_free_en && (fifo_cnt_q != '0);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (fifo_push) begin
         wr_ptr_d = (wr_ptr_q == FIFO_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
         rd_ptr_d = (rd_ptr_q == FIFO_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      if (fifo_push && !fifo_pop) begin
         fifo_cnt_d = fifo_cnt_q + 1'b1;
      end else if (!fifo_push && fifo_pop) begin
         fifo_cnt_d = fifo_cnt_q - 1'b1;
      end
      free_en_d  = cpl_free_en || fifo_pop;
      free_tag_d = '0;
      if (cpl_free_en) begin
         free_tag_d = cpl_free_tag;
      end else if (fifo_pop) begin
         free_tag_d = fifo_mem_q[rd_ptr_q];
      end
      ovf_d = ovf_q || fifo_drop;
   end

   always_comb begin
      used_cnt_d = used_cnt_q;
      if (alloc_q && !free_en_q) begin
         if (used_cnt_q != CNT_MAX) begin
            used_cnt_d = used_cnt_q + 1'b1;
         end
      end else if (!alloc_q && free_en_q) begin
         if (used_cnt_q != '0) begin
            used_cnt_d = used_cnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge pcie_user_clk or negedge pcie_user_rst_n) begin
      if (!pcie_user_rst_n) begin
         state_q    <= S_IDLE;
         rr_ptr_q   <= '0;
         winner_q   <= '0;
         gnt_q      <= '0;
         tag_q      <= '0;
         alloc_q    <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         free_en_q  <= 1'b0;
         free_tag_q <= '0;
         ovf_q      <= 1'b0;
         used_cnt_q <= '0;
         for (int i = 0; i < P_ABT_FIFO_DEPTH; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         winner_q   <= winner_d;
         gnt_q      <= gnt_d;
         tag_q      <= tag_d;
         alloc_q    <= alloc_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         free_en_q  <= free_en_d;
         free_tag_q <= free_tag_d;
         ovf_q      <= ovf_d;
         used_cnt_q <= used_cnt_d;
         if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= abt_free_tag;
         end
      end
   end

   assign req_slot_gnt          = gnt_q;
   assign req_slot_tag          = tag_q;
   assign hcmd_slot_alloc_en    = alloc_q;
   assign hcmd_slot_free_en     = free_en_q;
   assign hcmd_slot_invalid_tag = free_tag_q;
   assign abt_free_full         = (fifo_cnt_q == FIFO_FULL_CNT);
   assign free_ovf_err          = ovf_q;
   assign slot_used_cnt         = used_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pcie_hcmd_slot_arb.sv
`default_nettype none
// =============================================================================
// Module   : tb_pcie_hcmd_slot_arb
// Brief    : Vector table, corner sequences and random run against a queue model.
// Revision : 1.0 - initial release
// =============================================================================
module tb_pcie_hcmd_slot_arb;

   localparam int N = 4;
   localparam int W = 10;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b0;
   logic [N-1:0] req     = '0;
   logic         rdy     = 1'b0;
   logic [W-1:0] stag    = '0;
   logic         cpl_en  = 1'b0;
   logic [W-1:0] cpl_tag = '0;
   logic         abt_en  = 1'b0;
   logic [W-1:0] abt_tag = '0;

   logic [N-1:0] gnt;
   logic [W-1:0] gtag;
   logic         alloc;
   logic         fen;
   logic [W-1:0] ftag;
   logic         full;
   logic         ovf;
   logic [W:0]   cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pcie_hcmd_slot_arb #(
      .P_REQ_NUM        (N),
      .P_SLOT_TAG_WIDTH (W),
      .P_ABT_FIFO_DEPTH (4)
   ) u_dut (
      .pcie_user_clk         (clk),
      .pcie_user_rst_n       (rst_n),
      .req_slot_req          (req),
      .req_slot_gnt          (gnt),
      .req_slot_tag          (gtag),
      .hcmd_slot_rdy         (rdy),
      .hcmd_slot_tag         (stag),
      .hcmd_slot_alloc_en    (alloc),
      .cpl_free_en           (cpl_en),
      .cpl_free_tag          (cpl_tag),
      .abt_free_en           (abt_en),
      .abt_free_tag          (abt_tag),
      .hcmd_slot_free_en     (fen),
      .hcmd_slot_invalid_tag (ftag),
      .abt_free_full         (full),
      .free_ovf_err          (ovf),
      .slot_used_cnt         (cnt)
   );

   typedef struct {
      logic [3:0] rq;  logic rd;  logic [9:0] st;
      logic ce;  logic [9:0] ct;  logic ae;  logic [9:0] at;
      logic [3:0] g;  logic al;  logic [9:0] gt;
      logic fe;  logic [9:0] ft;  logic [10:0] c;
   } vec_t;

   vec_t tbl [19];

   function automatic vec_t mk(input logic [3:0] rq, input logic rd, input logic [9:0] st,
                               input logic ce, input logic [9:0] ct, input logic ae,
                               input logic [9:0] at, input logic [3:0] g, input logic al,
                               input logic [9:0] gt, input logic fe, input logic [9:0] ft,
                               input logic [10:0] c);
      vec_t v;
      v.rq = rq; v.rd = rd; v.st = st; v.ce = ce; v.ct = ct; v.ae = ae; v.at = at;
      v.g = g; v.al = al; v.gt = gt; v.fe = fe; v.ft = ft; v.c = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = '0; rdy = 1'b0; stag = '0;
      cpl_en = 1'b0; cpl_tag = '0; abt_en = 1'b0; abt_tag = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic wait_gnt(input string name, output bit seen);
      seen = 1'b0;
      for (int t = 0; t < 12 && !seen; t++) begin
         step();
         if (gnt != '0) seen = 1'b1;
      end
      chk(name, seen, 1);
   endtask

   function automatic int rr_pick(input int ptr, input logic [3:0] r);
      for (int i = 0; i < 4; i++) begin
         if (r[(ptr + i) % 4]) return (ptr + i) % 4;
      end
      return -1;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit           seen;
      bit           busy;
      int           launch, winner, ptr, mcnt, pre;
      bit           movf;
      logic [N-1:0] exp_gnt;
      bit           exp_alloc, exp_fen;
      logic [W-1:0] exp_ftag;
      logic [W-1:0] q[$];

      tbl[0]  = mk(4'b0100, 1'b1, 10'h3BC, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[1]  = mk(4'b0100, 1'b1, 10'h3BC, 1'b0, '0, 1'b0, '0, 4'b0100, 1'b1, 10'h3BC, 1'b0, '0, 11'd0);
      tbl[2]  = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd1);
      tbl[3]  = mk(4'b1000, 1'b1, 10'h011, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd1);
      tbl[4]  = mk(4'b1000, 1'b1, 10'h022, 1'b0, '0, 1'b0, '0, 4'b1000, 1'b1, 10'h022, 1'b0, '0, 11'd1);
      tbl[5]  = mk(4'b0000, 1'b1, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd2);
      tbl[6]  = mk(4'b0001, 1'b1, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd2);
      tbl[7]  = mk(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd2);
      tbl[8]  = mk(4'b0000, 1'b0, '0, 1'b1, 10'h005, 1'b1, 10'h009, 4'b0000, 1'b0, '0, 1'b1, 10'h005, 11'd2);
      tbl[9]  = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b1, 10'h009, 11'd1);
      tbl[10] = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[11] = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b1, 10'h02A, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[12] = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b1, 10'h02A, 11'd0);
      tbl[13] = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[14] = mk(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[15] = mk(4'b0001, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[16] = mk(4'b0001, 1'b1, 10'h3FF, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd0);
      tbl[17] = mk(4'b0001, 1'b1, 10'h3FF, 1'b0, '0, 1'b0, '0, 4'b0001, 1'b1, 10'h3FF, 1'b0, '0, 11'd0);
      tbl[18] = mk(4'b0000, 1'b0, '0, 1'b0, '0, 1'b0, '0, 4'b0000, 1'b0, '0, 1'b0, '0, 11'd1);

      // reset state
      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_tag", gtag, 0);
      chk("rst_alloc", alloc, 0);
      chk("rst_free_en", fen, 0);
      chk("rst_free_tag", ftag, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cnt", cnt, 0);

      // vector table
      for (int i = 0; i < 19; i++) begin
         req = tbl[i].rq; rdy = tbl[i].rd; stag = tbl[i].st;
         cpl_en = tbl[i].ce; cpl_tag = tbl[i].ct; abt_en = tbl[i].ae; abt_tag = tbl[i].at;
         step();
         chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].g);
         chk($sformatf("tbl%0d_alloc", i), alloc, tbl[i].al);
         if (tbl[i].g != '0) chk($sformatf("tbl%0d_tag", i), gtag, tbl[i].gt);
         chk($sformatf("tbl%0d_free_en", i), fen, tbl[i].fe);
         if (tbl[i].fe) chk($sformatf("tbl%0d_free_tag", i), ftag, tbl[i].ft);
         chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].c);
      end

      // round robin 0,1,2,3,0 with rdy dropping one cycle after each alloc
      do_reset();
      req = 4'b1111;
      rdy = 1'b1;
      for (int g = 0; g < 5; g++) begin
         wait_gnt("rr_timeout", seen);
         chk($sformatf("rr%0d_gnt", g), gnt, 32'd1 << (g % 4));
         chk($sformatf("rr%0d_alloc", g), alloc, 1);
         rdy = 1'b0;
         step();
         chk($sformatf("rr%0d_pulse", g), gnt, 0);
         rdy = 1'b1;
      end
      rdy = 1'b0;
      req = '0;

      // abort FIFO overflow behind a held completion stream, then drain
      for (int i = 0; i < 5; i++) begin
         cpl_en = 1'b1; cpl_tag = 10'(32'h100 + i);
         abt_en = 1'b1; abt_tag = 10'(32'h11 + i);
         step();
         chk($sformatf("ovf%0d_free_tag", i), ftag, 32'h100 + i);
         chk($sformatf("ovf%0d_full", i), full, (i >= 3) ? 1 : 0);
         chk($sformatf("ovf%0d_err", i), ovf, (i == 4) ? 1 : 0);
      end
      cpl_en = 1'b0;
      abt_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain%0d_en", i), fen, 1);
         chk($sformatf("drain%0d_tag", i), ftag, 32'h11 + i);
         chk($sformatf("drain%0d_full", i), full, 0);
      end
      step();
      chk("drain_done", fen, 0);
      chk("ovf_sticky", ovf, 1);

      // reset asserted while in S_GNT
      req = 4'b1110;
      rdy = 1'b1;
      step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_gnt", gnt, 0);
      chk("midrst_alloc", alloc, 0);
      chk("midrst_ovf", ovf, 0);
      chk("midrst_cnt", cnt, 0);
      step();
      chk("midrst_no_alloc", alloc, 0);
      rst_n = 1'b1;
      req = 4'b1111;
      wait_gnt("midrst_timeout", seen);
      chk("midrst_first_winner", gnt, 4'b0001);
      idle_inputs();

      // randomized run against the reference model
      do_reset();
      busy = 1'b0; launch = 0; winner = 0; ptr = 0; mcnt = 0; movf = 1'b0;
      q.delete();
      for (int k = 0; k < 600; k++) begin
         req     = 4'($urandom);
         rdy     = ($urandom_range(0, 3) != 0);
         stag    = 10'($urandom);
         cpl_en  = ($urandom_range(0, 2) == 0);
         cpl_tag = 10'($urandom);
         abt_en  = ($urandom_range(0, 1) == 1);
         abt_tag = 10'($urandom);

         exp_gnt   = '0;
         exp_alloc = 1'b0;
         if (busy && k == launch + 1) begin
            exp_gnt   = 4'(32'd1 << winner);
            exp_alloc = 1'b1;
         end
         pre      = q.size();
         exp_fen  = 1'b0;
         exp_ftag = '0;
         if (cpl_en) begin
            exp_fen  = 1'b1;
            exp_ftag = cpl_tag;
         end else if (pre > 0) begin
            exp_fen  = 1'b1;
            exp_ftag = q.pop_front();
         end
         if (abt_en) begin
            if (pre < 4) q.push_back(abt_tag);
            else movf = 1'b1;
         end

         step();
         chk("rnd_gnt", gnt, exp_gnt);
         chk("rnd_alloc", alloc, exp_alloc);
         if (exp_gnt != '0) chk("rnd_tag", gtag, stag);
         chk("rnd_free_en", fen, exp_fen);
         if (exp_fen) chk("rnd_free_tag", ftag, exp_ftag);
         chk("rnd_full", full, (q.size() == 4) ? 1 : 0);
         chk("rnd_ovf", ovf, movf);
         chk("rnd_cnt", cnt, mcnt);

         if (exp_alloc && !exp_fen) mcnt = (mcnt < 1024) ? mcnt + 1 : mcnt;
         else if (!exp_alloc && exp_fen) mcnt = (mcnt > 0) ? mcnt - 1 : 0;

         if (busy) begin
            if (k >= launch + 2 && !rdy) busy = 1'b0;
         end else if (rdy && req != '0) begin
            launch = k;
            winner = rr_pick(ptr, req);
            ptr    = (winner + 1) % 4;
            busy   = 1'b1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
